// File: rtl/posit_sched_pkg.sv
// Shared types and defaults for the posit adder scheduler.
// tag_t is sized for the largest supported requester count (8).
package posit_sched_pkg;

    localparam int unsigned POSIT_N         = 32;
    localparam int unsigned POSIT_ES        = 2;
    localparam int unsigned DEF_ADD_LATENCY = 4;
    localparam int unsigned MAX_TAG_W       = 3;

    typedef logic [MAX_TAG_W-1:0] tag_t;

    typedef struct packed {
        logic valid;
        tag_t tag;
    } tag_entry_t;

endpackage

// File: rtl/posit_add_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after a rotating pointer,
// then moves the pointer one past the winner.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned TAG_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [TAG_W-1:0]   o_idx
);

    logic [TAG_W-1:0] r_ptr;
    logic [TAG_W-1:0] w_cand;
    logic             w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_cand = TAG_W'((32'(r_ptr) + i) % NUM_REQ);
            if (i_en && !w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (o_idx == TAG_W'(NUM_REQ - 1)) ? '0 : o_idx + 1'b1;
        end
    end

endmodule

// File: rtl/posit_add_scheduler.sv
// Shares one pipelined posit adder between NUM_REQ requesters: round-robin accept,
// one-cycle issue register, tag pipe aligned to add_done, one-hot result routing.
module posit_add_scheduler
    import posit_sched_pkg::*;
#(
    parameter  int unsigned NUM_REQ     = 4,
    parameter  int unsigned N           = POSIT_N,
    parameter  int unsigned ADD_LATENCY = DEF_ADD_LATENCY,
    localparam int unsigned TAG_W       = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*N-1:0] req_in1,
    input  logic [NUM_REQ*N-1:0] req_in2,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [N-1:0]         rsp_result,
    output logic                 rsp_inf,
    output logic                 rsp_zero,
    output logic [N-1:0]         add_in1,
    output logic [N-1:0]         add_in2,
    output logic                 add_start,
    input  logic [N-1:0]         add_result,
    input  logic                 add_inf,
    input  logic                 add_zero,
    input  logic                 add_done,
    output logic [TAG_W+1:0]     in_flight,
    output logic                 err
);

    localparam int unsigned IF_W = TAG_W + 2;

    logic [NUM_REQ-1:0] w_grant;
    logic [TAG_W-1:0]   w_gidx;
    logic               w_accept;
    logic [N-1:0]       w_sel1;
    logic [N-1:0]       w_sel2;
    tag_entry_t         w_tail;
    logic               w_ret;
    logic [NUM_REQ-1:0] w_onehot;

    logic               r_issue;
    logic [N-1:0]       r_op1;
    logic [N-1:0]       r_op2;
    logic [TAG_W-1:0]   r_tag;
    tag_entry_t         r_pipe [ADD_LATENCY];
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [N-1:0]       r_rsp_result;
    logic               r_rsp_inf;
    logic               r_rsp_zero;
    logic [IF_W-1:0]    r_in_flight;
    logic               r_err;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_req   (req_valid),
        .i_en    (!reset),
        .o_grant (w_grant),
        .o_idx   (w_gidx)
    );

    assign req_ready = w_grant;
    assign w_accept  = |w_grant;

    always_comb begin
        w_sel1 = '0;
        w_sel2 = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel1 = req_in1[i*N +: N];
                w_sel2 = req_in2[i*N +: N];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_issue <= 1'b0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_tag   <= '0;
        end else begin
            r_issue <= w_accept;
            if (w_accept) begin
                r_op1 <= w_sel1;
                r_op2 <= w_sel2;
                r_tag <= w_gidx;
            end
        end
    end

    assign add_in1   = r_op1;
    assign add_in2   = r_op2;
    assign add_start = r_issue;

    // Entry pushed on the add_start cycle reaches the tail exactly when add_done is due.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ADD_LATENCY; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= '{valid: r_issue, tag: tag_t'(r_tag)};
            for (int unsigned i = 1; i < ADD_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign w_tail = r_pipe[ADD_LATENCY-1];
    assign w_ret  = add_done && w_tail.valid;

    always_comb begin
        w_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) w_onehot[i] = (w_tail.tag == tag_t'(i));
    end

    // in_flight counts from acceptance, so the issue register is included (peak ADD_LATENCY+1).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
            r_rsp_inf    <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_in_flight  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_rsp_valid <= w_ret ? w_onehot : '0;
            if (w_ret) begin
                r_rsp_result <= add_result;
                r_rsp_inf    <= add_inf;
                r_rsp_zero   <= add_zero;
            end
            if (add_done != w_tail.valid) r_err <= 1'b1;
            r_in_flight <= r_in_flight + IF_W'(w_accept) - IF_W'(w_tail.valid);
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_inf    = r_rsp_inf;
    assign rsp_zero   = r_rsp_zero;
    assign in_flight  = r_in_flight;
    assign err        = r_err;

endmodule

// File: tb/tb_posit_add_scheduler.sv
// Self-checking bench for posit_add_scheduler: directed table, multi-cycle corner
// sequences and random traffic against a cycle-indexed scoreboard and a real-valued posit model.
module tb_posit_add_scheduler;

    localparam int NR   = 4;
    localparam int N    = 32;
    localparam int L    = 4;
    localparam int TW   = 2;
    localparam int MAXC = 4096;
    localparam logic [31:0] NAR = 32'h8000_0000;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid, req_ready, rsp_valid;
    logic [NR*N-1:0]   req_in1, req_in2;
    logic [N-1:0]      rsp_result, add_in1, add_in2, add_result;
    logic              rsp_inf, rsp_zero, add_start, add_inf, add_zero, add_done, err;
    logic [TW+1:0]     in_flight;

    always #5 clk = ~clk;

    posit_add_scheduler #(.NUM_REQ(NR), .N(N), .ADD_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2), .rsp_valid(rsp_valid),
        .rsp_result(rsp_result), .rsp_inf(rsp_inf), .rsp_zero(rsp_zero),
        .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start),
        .add_result(add_result), .add_inf(add_inf), .add_zero(add_zero),
        .add_done(add_done), .in_flight(in_flight), .err(err)
    );

    typedef struct packed { logic [31:0] r; logic inf; logic zero; } res_t;
    typedef struct { int due; res_t res; } ad_t;
    typedef struct { int req; logic [31:0] a; logic [31:0] b; logic [31:0] r; bit inf; bit zero; } vec_t;

    int checks = 0, errors = 0, cyc = 0, ptr_m = 0, max_if = 0;
    bit          acc_v [MAXC];
    int          acc_g [MAXC];
    logic [31:0] acc_a [MAXC], acc_b [MAXC];
    res_t        acc_r [MAXC];
    bit [NR-1:0] exp_rv [MAXC];
    res_t        exp_rs [MAXC];
    bit exp_err = 0, err_next = 0, drop_next = 0, inject_spurious = 0;
    ad_t adq [$];
    int grants [$];
    logic [NR-1:0] rsp_log [$];
    bit got_rsp; logic [31:0] got_res; bit got_inf, got_zero;
    logic [31:0] op1 [NR], op2 [NR];
    vec_t tbl [8];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Posit(32,2) decode to real
    function automatic real p2r(logic [31:0] p);
        logic [31:0] m; int i, run, k, e, fb; real f, r;
        if (p == 0) return 0.0;
        m = p[31] ? -p : p;
        run = 0; i = 30;
        while (i >= 0 && m[i] == m[30]) begin run++; i--; end
        k = m[30] ? run - 1 : -run;
        i--;
        e = 0;
        for (int j = 0; j < 2; j++) begin
            e = e * 2;
            if (i >= 0) begin e += int'(m[i]); i--; end
        end
        fb = i + 1;
        f = 1.0;
        if (fb > 0) f = 1.0 + real'(m & ((32'h1 << fb) - 1)) / (2.0 ** fb);
        r = f * (2.0 ** (4 * k + e));
        return p[31] ? -r : r;
    endfunction

    // Real to posit(32,2), round to nearest even on the bit pattern
    function automatic logic [31:0] r2p(real xin);
        real x; logic [63:0] b; logic [127:0] body; int sc, k, e, pos;
        logic [30:0] top; logic g, s; logic [31:0] res; bit neg;
        x = xin;
        if (x == 0.0) return 32'h0;
        neg = (x < 0.0);
        if (neg) x = -x;
        b = $realtobits(x);
        sc = int'(b[62:52]) - 1023;
        k = sc >>> 2;
        e = sc - 4 * k;
        body = '0; pos = 127;
        if (k >= 0) begin
            for (int j = 0; j <= k; j++) begin body[pos] = 1'b1; pos--; end
            pos--;
        end else begin
            pos -= -k;
            body[pos] = 1'b1;
            pos--;
        end
        body[pos] = e[1]; body[pos-1] = e[0]; pos -= 2;
        for (int j = 51; j >= 0; j--) begin body[pos] = b[j]; pos--; end
        top = body[127:97]; g = body[96]; s = |body[95:0];
        if (g && (s || top[0])) top = top + 31'd1;
        res = {1'b0, top};
        return neg ? -res : res;
    endfunction

    function automatic res_t ref_add(logic [31:0] a, logic [31:0] b);
        real x;
        if (a == NAR || b == NAR) return '{NAR, 1'b1, 1'b0};
        x = p2r(a) + p2r(b);
        if (x == 0.0) return '{32'h0, 1'b0, 1'b1};
        return '{r2p(x), 1'b0, 1'b0};
    endfunction

    // Random posit with small regime so the real-valued sum stays exact
    function automatic logic [31:0] rand_posit();
        logic [31:0] p, m; int run;
        for (int n = 0; n < 100; n++) begin
            p = $urandom;
            if (p == 0 || p == NAR) continue;
            m = p[31] ? -p : p;
            run = 0;
            for (int i = 30; i >= 0 && m[i] == m[30]; i--) run++;
            if (run <= 3 && (m[30] ? run - 1 : -run) >= -2) return p;
        end
        return 32'h4000_0000;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < NR; i++) begin op1[i] = rand_posit(); op2[i] = rand_posit(); end
    endtask

    function automatic bit acc_at(int t);
        return (t >= 0 && t < MAXC) ? acc_v[t] : 1'b0;
    endfunction

    function automatic int if_model(int c);
        int n = 0;
        for (int t = c - L - 1; t <= c - 1; t++) if (acc_at(t)) n++;
        return n;
    endfunction

    task automatic step(input logic [NR-1:0] v, input bit rst);
        int eg, idx, t; bit due; ad_t ent; res_t rr;
        @(posedge clk); #1; cyc++;
        chk("rsp_valid", rsp_valid, exp_rv[cyc]);
        if (exp_rv[cyc] != 0) begin
            chk("rsp_result", rsp_result, exp_rs[cyc].r);
            chk("rsp_inf", rsp_inf, exp_rs[cyc].inf);
            chk("rsp_zero", rsp_zero, exp_rs[cyc].zero);
        end
        if (rsp_valid != 0) begin
            got_rsp = 1; got_res = rsp_result; got_inf = rsp_inf; got_zero = rsp_zero;
            rsp_log.push_back(rsp_valid);
        end
        chk("add_start", add_start, acc_at(cyc - 1));
        if (acc_at(cyc - 1)) begin
            chk("add_in1", add_in1, acc_a[cyc-1]);
            chk("add_in2", add_in2, acc_b[cyc-1]);
        end
        chk("in_flight", in_flight, if_model(cyc));
        exp_err = exp_err | err_next; err_next = 0;
        chk("err", err, exp_err);
        if (int'(in_flight) > max_if) max_if = int'(in_flight);
        if (add_start) adq.push_back('{cyc + L, ref_add(add_in1, add_in2)});

        reset = rst; req_valid = v;
        for (int i = 0; i < NR; i++) begin req_in1[i*N +: N] = op1[i]; req_in2[i*N +: N] = op2[i]; end
        add_done = 0; add_result = '0; add_inf = 0; add_zero = 0;
        if (!rst && adq.size() > 0 && adq[0].due == cyc) begin
            ent = adq.pop_front();
            if (drop_next) drop_next = 0;
            else begin
                add_done = 1; add_result = ent.res.r; add_inf = ent.res.inf; add_zero = ent.res.zero;
            end
        end
        if (!rst && inject_spurious) begin
            add_done = 1; add_result = 32'h1234_5678; inject_spurious = 0;
        end
        if (rst) begin
            for (int i = 0; i < MAXC; i++) begin acc_v[i] = 0; exp_rv[i] = '0; end
            adq.delete(); exp_err = 0; err_next = 0; drop_next = 0;
        end else begin
            t = cyc - 1 - L;
            due = acc_at(t);
            if (add_done != due) err_next = 1;
            if (due && add_done && cyc + 1 < MAXC) begin
                exp_rv[cyc+1] = NR'(1) << acc_g[t];
                exp_rs[cyc+1] = acc_r[t];
            end
        end
        #1;
        eg = -1;
        if (!rst) for (int i = 0; i < NR; i++) begin
            idx = (ptr_m + i) % NR;
            if (eg < 0 && v[idx]) eg = idx;
        end
        chk("req_ready", req_ready, (eg >= 0) ? (NR'(1) << eg) : '0);
        if (eg >= 0) begin
            rr = ref_add(op1[eg], op2[eg]);
            acc_v[cyc] = 1; acc_g[cyc] = eg; acc_a[cyc] = op1[eg]; acc_b[cyc] = op2[eg]; acc_r[cyc] = rr;
            ptr_m = (eg + 1) % NR;
            grants.push_back(eg);
        end
        if (rst) ptr_m = 0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step('0, 0);
    endtask

    initial begin
        tbl[0] = '{2, 32'h0202F9D4, 32'h6C4C09CA, 32'h6C4C09CB, 0, 0};
        tbl[1] = '{0, 32'h40000000, 32'h40000000, 32'h48000000, 0, 0};
        tbl[2] = '{1, 32'h40000000, 32'hC0000000, 32'h00000000, 0, 1};
        tbl[3] = '{3, 32'h40000000, 32'h48000000, 32'h4C000000, 0, 0};
        tbl[4] = '{1, 32'h60000000, 32'h60000000, 32'h64000000, 0, 0};
        tbl[5] = '{0, 32'h38000000, 32'h38000000, 32'h40000000, 0, 0};
        tbl[6] = '{2, 32'h80000000, 32'h40000000, 32'h80000000, 1, 0};
        tbl[7] = '{3, 32'h00000000, 32'h40000000, 32'h40000000, 0, 0};

        reset = 1; req_valid = '0; req_in1 = '0; req_in2 = '0;
        add_done = 0; add_result = '0; add_inf = 0; add_zero = 0;
        rand_ops();
        step('0, 1); step('0, 1);
        chk("rst_add_in1", add_in1, 0);
        chk("rst_add_in2", add_in2, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_flags", {rsp_inf, rsp_zero}, 0);
        step('0, 0);

        // Directed single requests
        for (int r = 0; r < 8; r++) begin
            got_rsp = 0;
            op1[tbl[r].req] = tbl[r].a; op2[tbl[r].req] = tbl[r].b;
            step(NR'(1) << tbl[r].req, 0);
            for (int n = 0; n < L + 4 && !got_rsp; n++) step('0, 0);
            chk("tbl_seen", got_rsp, 1);
            chk("tbl_result", got_res, tbl[r].r);
            chk("tbl_inf", got_inf, tbl[r].inf);
            chk("tbl_zero", got_zero, tbl[r].zero);
            step('0, 0);
            chk("tbl_in_flight0", in_flight, 0);
        end

        // All four requesters for 8 cycles from ptr=0
        step('0, 1);
        grants.delete(); rsp_log.delete();
        for (int i = 0; i < 8; i++) begin rand_ops(); step('1, 0); end
        idle(L + 4);
        chk("rr_all_count", grants.size(), 8);
        chk("rsp_all_count", rsp_log.size(), 8);
        for (int i = 0; i < 8 && i < grants.size() && i < rsp_log.size(); i++) begin
            chk("rr_all_order", grants[i], i % 4);
            chk("rsp_all_order", rsp_log[i], NR'(1) << (i % 4));
        end

        // Requesters 1 and 3 with ptr=2
        step(4'b0010, 0);
        idle(L + 3);
        grants.delete();
        for (int i = 0; i < 6; i++) begin rand_ops(); step(4'b1010, 0); end
        idle(L + 3);
        for (int i = 0; i < 6 && i < grants.size(); i++) chk("rr_13_order", grants[i], (i % 2 == 0) ? 3 : 1);

        // Back-to-back issue with concurrent returns
        max_if = 0;
        for (int i = 0; i < 20; i++) begin rand_ops(); step('1, 0); end
        idle(L + 3);
        chk("in_flight_peak", max_if, L + 1);
        chk("b2b_no_err", err, 0);

        // Expected add_done withheld: operation dropped
        got_rsp = 0;
        rand_ops(); step(4'b0001, 0);
        drop_next = 1;
        idle(L + 4);
        chk("drop_err", err, 1);
        chk("drop_no_rsp", got_rsp, 0);
        chk("drop_in_flight0", in_flight, 0);

        // Spurious add_done with empty tag pipe
        step('0, 1);
        idle(2);
        got_rsp = 0;
        inject_spurious = 1;
        step('0, 0);
        step('0, 0);
        chk("spurious_err", err, 1);
        idle(4);
        chk("spurious_err_sticky", err, 1);
        chk("spurious_no_rsp", got_rsp, 0);

        // Reset with three operations in flight
        step('0, 1);
        rand_ops();
        step(4'b0111, 0); step(4'b0110, 0); step(4'b0100, 0);
        got_rsp = 0;
        step('0, 1);
        idle(L + 4);
        chk("rst_mid_no_rsp", got_rsp, 0);
        chk("rst_mid_in_flight", in_flight, 0);
        grants.delete();
        rand_ops(); step(4'b1010, 0);
        chk("rst_mid_ptr0", (grants.size() > 0) ? grants[0] : -1, 1);
        for (int n = 0; n < L + 4 && !got_rsp; n++) step('0, 0);
        chk("rst_mid_new_rsp", got_rsp, 1);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            rand_ops();
            step(NR'($urandom_range(0, (1 << NR) - 1)), 0);
        end
        idle(L + 4);
        chk("random_in_flight0", in_flight, 0);
        chk("random_no_err", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
